// File: rtl/stream_arb_pkg.sv
// Shared types for the packet-granular stream arbiter: FSM states, header layout
// and the helper that packs a header word.
package stream_arb_pkg;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam int         GRANT_W   = 3;
  localparam int         SEQ_W     = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [7:0]       magic;
    logic [7:0]       src;
    logic [15:0]      rsvd;
    logic [SEQ_W-1:0] seq;
  } hdr_t;

  function automatic logic [63:0] make_header(input logic [GRANT_W-1:0] src,
                                              input logic [SEQ_W-1:0]   seq);
    hdr_t h;
    h.magic = HDR_MAGIC;
    h.src   = {5'b0, src};
    h.rsvd  = 16'h0000;
    h.seq   = seq;
    return h;
  endfunction

endpackage

// File: rtl/stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting source strictly after
// last_i, wrapping modulo NUM_SRC; last_i itself has the lowest priority.
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [GRANT_W-1:0] last_i,
  output logic [GRANT_W-1:0] idx_o,
  output logic               found_o
);

  logic [7:0] req_ext;

  function automatic logic [GRANT_W-1:0] wrap_add(input logic [GRANT_W-1:0] base,
                                                  input int                 off);
    int sum;
    sum = int'(base) + off;
    return GRANT_W'(sum % NUM_SRC);
  endfunction

  assign req_ext = 8'(req_i);

  // Walk offsets from farthest to nearest so the nearest hit is the one kept.
  always_comb begin
    idx_o   = last_i;
    found_o = 1'b0;
    for (int off = NUM_SRC; off >= 1; off--) begin
      if (req_ext[wrap_add(last_i, off)]) begin
        idx_o   = wrap_add(last_i, off);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_arbiter.sv
// Packet round-robin merge of NUM_SRC AXI-Stream sources into one 64-bit stream;
// every packet is preceded by a header word {magic, src, rsvd, seq}.
module stream_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 ena,
  input  logic                                 clear_counters,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_SRC-1:0]                   s_tvalid,
  input  logic [NUM_SRC-1:0]                   s_tlast,
  output logic [NUM_SRC-1:0]                   s_tready,
  output logic [DATA_WIDTH-1:0]                m_tdata,
  output logic                                 m_tvalid,
  output logic                                 m_tlast,
  input  logic                                 m_tready,
  output logic                                 busy,
  output logic [GRANT_W-1:0]                   grant,
  output logic [NUM_SRC-1:0][SEQ_W-1:0]        seq_count,
  output arb_state_e                           dbg_state
);

  // Handshake: a beat moves on either side only in a cycle where valid and
  // ready are both high; valid never waits on ready, and a stalled beat
  // (valid high, ready low) keeps its data unchanged until it is taken.

  arb_state_e                     state_q, state_d;
  logic [GRANT_W-1:0]             grant_q, grant_d;
  logic [63:0]                    hdr_q, hdr_d;
  logic [NUM_SRC-1:0][SEQ_W-1:0]  seq_q, seq_d;

  logic [GRANT_W-1:0]             pick_idx;
  logic                           pick_found;
  logic [SEQ_W-1:0]               pick_seq;
  logic [DATA_WIDTH-1:0]          sel_data;
  logic                           sel_valid;
  logic                           sel_last;
  logic                           pkt_done;

  rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req_i   (s_tvalid),
    .last_i  (grant_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin : src_mux
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    pick_seq  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == GRANT_W'(i)) begin
        sel_data  = s_tdata[i];
        sel_valid = s_tvalid[i];
        sel_last  = s_tlast[i];
      end
      if (pick_idx == GRANT_W'(i)) begin
        pick_seq = seq_q[i];
      end
    end
  end

  // The header is captured at the grant decision so a clear_counters pulse
  // during a stalled header cannot change a word already on the bus.
  always_comb begin : fsm_comb
    state_d  = state_q;
    grant_d  = grant_q;
    hdr_d    = hdr_q;
    pkt_done = 1'b0;
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    busy     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ena && pick_found) begin
          grant_d = pick_idx;
          hdr_d   = make_header(pick_idx, pick_seq);
          state_d = HEADER;
        end
      end
      HEADER: begin
        busy     = 1'b1;
        m_tvalid = 1'b1;
        m_tdata  = DATA_WIDTH'(hdr_q);
        if (m_tready) begin
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        busy     = 1'b1;
        m_tdata  = sel_data;
        m_tvalid = sel_valid;
        m_tlast  = sel_last;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (grant_q == GRANT_W'(i)) begin
            s_tready[i] = m_tready;
          end
        end
        if (sel_valid && m_tready && sel_last) begin
          pkt_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A clear wins over an increment landing in the same cycle.
  always_comb begin : seq_comb
    seq_d = seq_q;
    if (clear_counters) begin
      seq_d = '0;
    end else if (pkt_done) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant_q == GRANT_W'(i)) begin
          seq_d[i] = seq_q[i] + SEQ_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= GRANT_W'(NUM_SRC - 1);
      hdr_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      hdr_q   <= hdr_d;
      seq_q   <= seq_d;
    end
  end

  assign grant     = grant_q;
  assign seq_count = seq_q;
  assign dbg_state = state_q;

endmodule
